// File: rtl/mem_pkg.sv
// Shared encodings for the extended data memory: access sizes and clear-FSM states.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: picks the addressed byte/halfword out of a RAM word,
// right-justifies it and sign- or zero-extends it to 32 bits.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_sext;
    logic signed [31:0] half_sext;

    // Lane selection and extension for every supported access size
    always_comb begin
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel  = lane[1] ? word[31:16] : word[15:0];
        byte_s    = byte_sel;
        half_s    = half_sel;
        byte_sext = byte_s;
        half_sext = half_s;

        case (size)
            SZ_BYTE: result = sign_ext ? 32'(byte_sext) : {24'b0, byte_sel};
            SZ_HALF: result = sign_ext ? 32'(half_sext) : {16'b0, half_sel};
            SZ_WORD: result = word;
            default: result = 32'b0;
        endcase
    end

endmodule

// File: rtl/data_memory_ext.sv
// Data memory for the CPU MEM path: byte/halfword/word access with extension,
// alignment and range fault detection with a sticky fault record, and a
// post-reset sequencer that zeroes the RAM one word per cycle.
module data_memory_ext
    import mem_pkg::*;
#(
    parameter int RAM_SIZE_BIT = 8
)
(
    input  logic        reset,
    input  logic        clk,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic        FaultClear,
    output logic [31:0] Read_data,
    output logic        Ready,
    output logic        Fault,
    output logic        FaultValid,
    output logic [31:0] FaultAddr,
    output logic        FaultIsWrite
);

    localparam int RAM_SIZE = 2 ** RAM_SIZE_BIT;

    logic [31:0] ram [RAM_SIZE];

    state_t                  state;
    logic [RAM_SIZE_BIT-1:0] index;

    logic [RAM_SIZE_BIT-1:0] word_idx;
    logic [1:0]              lane;
    logic                    request;
    logic                    misaligned;
    logic                    illegal_size;
    logic                    out_of_range;
    logic                    access_ok;
    logic                    wr_en;
    logic [3:0]              lane_en;
    logic [31:0]             lane_data;
    logic [31:0]             load_result;

    assign word_idx = Address[RAM_SIZE_BIT+1:2];
    assign lane     = Address[1:0];
    assign request  = MemRead | MemWrite;

    // Fault classification; requests are only honoured once the clear is done
    always_comb begin
        misaligned   = 1'b0;
        illegal_size = 1'b0;
        case (MemSize)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = Address[0];
            SZ_WORD: misaligned = |Address[1:0];
            default: illegal_size = 1'b1;
        endcase
        out_of_range = |(Address >> (RAM_SIZE_BIT + 2));
        Fault        = request & Ready & (misaligned | illegal_size | out_of_range);
        access_ok    = Ready & ~Fault;
        wr_en        = MemWrite & access_ok;
    end

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        case (MemSize)
            SZ_BYTE: begin
                lane_en   = 4'b0001 << lane;
                lane_data = {4{Write_data[7:0]}};
            end
            SZ_HALF: begin
                lane_en   = lane[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{Write_data[15:0]}};
            end
            SZ_WORD: begin
                lane_en   = 4'b1111;
                lane_data = Write_data;
            end
            default: begin
                lane_en   = 4'b0000;
                lane_data = 32'b0;
            end
        endcase
    end

    mem_load_align u_align (
        .word     (ram[word_idx]),
        .lane     (lane),
        .size     (MemSize),
        .sign_ext (MemSigned),
        .result   (load_result)
    );

    assign Read_data = (MemRead & access_ok) ? load_result : 32'b0;

    // RAM port: clear sequencer owns the array until RUN, then lane-masked stores
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            ram[index] <= 32'b0;
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    ram[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // Clear FSM: walk every word once after reset, then raise Ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_CLEAR;
            index <= '0;
            Ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    index <= index + 1'b1;
                    if (index == RAM_SIZE_BIT'(RAM_SIZE - 1)) begin
                        state <= ST_RUN;
                        Ready <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Sticky fault record: first fault wins, a new fault beats a coincident clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FaultValid   <= 1'b0;
            FaultAddr    <= 32'b0;
            FaultIsWrite <= 1'b0;
        end else if (Fault && (!FaultValid || FaultClear)) begin
            FaultValid   <= 1'b1;
            FaultAddr    <= Address;
            FaultIsWrite <= MemWrite;
        end else if (FaultClear) begin
            FaultValid   <= 1'b0;
        end
    end

endmodule

// File: doc/data_memory_ext.md
# data_memory_ext

Parameterised successor to the single-cycle CPU's word-only data memory. It sits on the CPU's MEM path and adds several capabilities:
- byte, halfword and word loads and stores, with sign or zero extension on loads;
- fault detection for misaligned and out-of-range accesses, with a sticky fault record;
- a hardware clear sequencer that zeroes the RAM one word per cycle after reset, replacing a single-cycle bulk clear.

## Interface
Parameters:
- RAM_SIZE_BIT, 8: log2 of word count. The RAM holds RAM_SIZE = 2**RAM_SIZE_BIT 32-bit words.

Ports:
- reset  in  1  asynchronous, active-low
- clk  in  1  clock
- Address  in  32  byte address
- Write_data  in  32  store data; the low bits are used for sub-word stores
- MemRead  in  1  load request
- MemWrite  in  1  store request
- MemSize  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal (always faults)
- MemSigned  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
- FaultClear  in  1  clears the sticky fault record
- Read_data  out  32  combinational load result
- Ready  out  1  registered; 0 while clearing
- Fault  out  1  combinational; the current request faults
- FaultValid  out  1  registered; the sticky fault record is valid
- FaultAddr  out  32  registered; address of the first captured fault
- FaultIsWrite  out  1  registered; the first captured fault was a store

## Operation
- Word index is Address[RAM_SIZE_BIT+1:2]. Byte lane is Address[1:0]. Byte ordering is little-endian: lane 0 = bits 7:0.
- Request: MemRead or MemWrite is high.
- Fault is asserted when a request is present and any of the following holds:
  - the access is misaligned: halfword with Address[0]=1, or word with Address[1:0]≠0;
  - MemSize=11;
  - the address is out of range: Address[31:RAM_SIZE_BIT+2]≠0.
- Read_data:
  - 0 unless MemRead, Ready and !Fault all hold;
  - otherwise the selected byte or halfword is right-justified and extended according to MemSigned; a word load returns the full word.
- Stores:
  - on posedge clk when MemWrite, Ready and !Fault all hold;
  - only the addressed lanes are written: Write_data[7:0] for a byte, [15:0] for a halfword, all 32 bits for a word;
  - other lanes are preserved.
- A faulting store writes nothing.
- Requests issued while Ready=0 are ignored: no write, Read_data=0, Fault=0.
- Clear FSM has two states, CLEAR and RUN, with a RAM_SIZE_BIT-bit index counter:
  - while reset is asserted: state=CLEAR, index=0, Ready=0;
  - CLEAR: on each posedge, write 0 to RAM[index] and increment index. When index=RAM_SIZE-1, go to RUN and set Ready=1.
  - RUN: remain in RUN until reset.
- Sticky fault record:
  - on posedge, when Fault and !FaultValid, capture FaultValid=1, FaultAddr=Address and FaultIsWrite=MemWrite;
  - later faults do not overwrite the record;
  - FaultClear clears FaultValid. If FaultClear coincides with a new fault, the new fault is captured (set wins).
- Simultaneous MemRead and MemWrite to the same word: Read_data shows the old contents until the edge, and the write commits at the edge.

## Timing
- Reset values: Ready=0, FaultValid=0, FaultAddr=0, FaultIsWrite=0. Read_data and Fault are 0 because Ready=0.
- The clear takes exactly RAM_SIZE posedges after reset deassertion. Ready rises after the RAM_SIZE-th edge.
- Reset asserted mid-clear restarts the clear from index 0. Reset asserted in RUN reruns the full clear.
- Load latency is 0 cycles (combinational). A store is visible to a load in the cycle after its write edge.
- Fault is combinational in the request cycle. FaultValid is high after that cycle's edge.

## Structure
- Shared package mem_pkg holds:
  - MemSize encodings: SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state constants: ST_CLEAR, ST_RUN.
- Sub-module mem_load_align is combinational. It takes the word, the lane, MemSize and MemSigned and produces the extended 32-bit result.
- The RAM array and byte-lane write logic remain in the top module.

## Test plan
- Reset, then idle. Ready must be 0 for exactly 256 edges, then 1. A word load from 0x00 must return 0x00000000.
- Word store 0x11223344 to 0x10, then byte store 0xAA to 0x11. A word load from 0x10 must return 0x1122AA44.
- With word 0x10 = 0x8000FF80:
  - signed byte load from 0x10 must return 0xFFFFFF80; unsigned must return 0x00000080;
  - signed halfword load from 0x12 must return 0xFFFF8000.
- Word store to 0x06:
  - Fault=1 and no RAM change;
  - FaultValid=1, FaultAddr=0x06, FaultIsWrite=1;
  - a second fault at 0x400 leaves the record unchanged;
  - FaultClear together with a byte load at 0x400 must recapture FaultAddr=0x400.
- Store 0x5 to 0x20, assert reset mid-run, then release. Ready must stay 0 for 256 edges. A load from 0x20 must then return 0.
- Store 0xDEAD to 0x30 while Ready=0. After Ready rises, a load from 0x30 must return 0.
